// File: rtl/freq_pkg.sv
// freq_pkg: shared constants for the frequency-counter datapath.
// Gate sequencer state encodings and default gate timing.
package freq_pkg;

    // Gate sequencer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_GATE    = 3'd2;
    localparam logic [2:0] ST_CONVERT = 3'd3;
    localparam logic [2:0] ST_LOAD    = 3'd4;

    // Gate timing shared with the frequency counter top
    localparam int GATE_BITS      = 12;
    localparam int DEFAULT_PERIOD = 1200;
    localparam int MIN_PERIOD     = 16;
    localparam int CONV_TIMEOUT   = 64;

endpackage

// File: rtl/gate_sequencer_if.sv
// gate_sequencer_if: control/status bundle between the gate sequencer
// and the period pins, edge counter, BCD converter and display.
interface gate_sequencer_if #(
    parameter int BITS = 12
);

    logic [BITS-1:0] period;
    logic            period_load;
    logic            enable;
    logic            convert_done;
    logic            count_clear;
    logic            count_en;
    logic            convert_start;
    logic            display_load;
    logic            busy;
    logic            conv_error;

    // Surrounding datapath side
    modport master (
        output period, period_load, enable, convert_done,
        input  count_clear, count_en, convert_start,
        input  display_load, busy, conv_error
    );

    // Sequencer side
    modport slave (
        input  period, period_load, enable, convert_done,
        output count_clear, count_en, convert_start,
        output display_load, busy, conv_error
    );

endinterface

// File: rtl/gate_sequencer_period_shadow.sv
// period_shadow: clamps a requested gate length to the minimum and
// holds it until the sequencer picks it up at the next CLEAR.
module period_shadow #(
    parameter int BITS           = freq_pkg::GATE_BITS,
    parameter int DEFAULT_PERIOD = freq_pkg::DEFAULT_PERIOD,
    parameter int MIN_PERIOD     = freq_pkg::MIN_PERIOD
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [BITS-1:0] period,
    input  logic            period_load,
    output logic [BITS-1:0] shadow
);

    localparam logic [BITS-1:0] W_DEF = BITS'(DEFAULT_PERIOD);
    localparam logic [BITS-1:0] W_MIN = BITS'(MIN_PERIOD);

    logic [BITS-1:0] r_shadow;

    // Capture a clamped period whenever a load is requested
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= W_DEF;
        end else if (period_load) begin
            r_shadow <= (period < W_MIN) ? W_MIN : period;
        end
    end

    assign shadow = r_shadow;

endmodule

// File: rtl/gate_sequencer.sv
// gate_sequencer: measurement-window FSM (clear, gate, convert, load).
// Define GATE_TIMEOUT_EN to add the converter watchdog and conv_error.
module gate_sequencer #(
    parameter int BITS           = freq_pkg::GATE_BITS,
    parameter int DEFAULT_PERIOD = freq_pkg::DEFAULT_PERIOD,
    parameter int MIN_PERIOD     = freq_pkg::MIN_PERIOD,
    parameter int CONV_TIMEOUT   = freq_pkg::CONV_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    gate_sequencer_if.slave  bus
);

    import freq_pkg::*;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [BITS-1:0] r_gate_cnt;
    logic [BITS-1:0] w_shadow;
    logic            r_count_clear;
    logic            r_count_en;
    logic            r_convert_start;
    logic            r_display_load;
    logic            r_busy;
    logic            w_done_seen;
    logic            w_timeout;

    period_shadow #(
        .BITS           (BITS),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .MIN_PERIOD     (MIN_PERIOD)
    ) u_shadow (
        .clk         (clk),
        .reset_n     (reset_n),
        .period      (bus.period),
        .period_load (bus.period_load),
        .shadow      (w_shadow)
    );

    // Done is ignored in the cycle that carries the start pulse
    assign w_done_seen = bus.convert_done && !r_convert_start;

`ifdef GATE_TIMEOUT_EN
    localparam int WDW = $clog2(CONV_TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(CONV_TIMEOUT - 1);

    logic [WDW-1:0] r_wd;
    logic           r_conv_error;

    assign w_timeout = (r_state == ST_CONVERT) && !w_done_seen
                       && (r_wd == WD_LAST);

    // Watchdog: cycles spent in CONVERT, cleared in any other state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd <= '0;
        end else if (r_state == ST_CONVERT) begin
            r_wd <= r_wd + WDW'(1);
        end else begin
            r_wd <= '0;
        end
    end

    // Sticky error once the converter has missed its deadline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conv_error <= 1'b0;
        end else if (w_timeout) begin
            r_conv_error <= 1'b1;
        end
    end

    assign bus.conv_error = r_conv_error;
`else
    assign w_timeout      = 1'b0;
    assign bus.conv_error = 1'b0;
`endif

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.enable) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_next = ST_GATE;
            end
            ST_GATE: begin
                if (r_gate_cnt == '0) w_next = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (w_done_seen) begin
                    w_next = ST_LOAD;
                end else if (w_timeout) begin
                    w_next = bus.enable ? ST_CLEAR : ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_next = bus.enable ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Gate down-counter: loaded in CLEAR, runs to zero in GATE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gate_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_gate_cnt <= w_shadow - BITS'(1);
        end else if (r_state == ST_GATE && r_gate_cnt != '0) begin
            r_gate_cnt <= r_gate_cnt - BITS'(1);
        end
    end

    // Outputs registered from the upcoming state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count_clear   <= 1'b0;
            r_count_en      <= 1'b0;
            r_convert_start <= 1'b0;
            r_display_load  <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_count_clear   <= (w_next == ST_CLEAR);
            r_count_en      <= (w_next == ST_GATE);
            r_convert_start <= (w_next == ST_CONVERT)
                               && (r_state != ST_CONVERT);
            r_display_load  <= (w_next == ST_LOAD);
            r_busy          <= (w_next != ST_IDLE);
        end
    end

    assign bus.count_clear   = r_count_clear;
    assign bus.count_en      = r_count_en;
    assign bus.convert_start = r_convert_start;
    assign bus.display_load  = r_display_load;
    assign bus.busy          = r_busy;

endmodule

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer: randomized and directed bench for gate_sequencer,
// checked every cycle against a measurement-schedule model.
module tb_gate_sequencer;

    localparam int BITS = 12;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    gate_sequencer_if #(.BITS(BITS)) bus();

    gate_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Model: one measurement = CLEAR at m_start, gate m_len, then convert
    bit m_active;
    bit m_hold;
    bit m_err;
    int m_start;
    int m_len;
    int m_lat;
    int m_end;
    int m_shadow;

    // Stimulus knobs
    bit g_en;
    bit g_noise;
    bit g_hold;
    bit g_ld;
    int g_lat;
    int g_pv;

    // Observations of the DUT
    int clears;
    int loads;
    int starts;
    int run;
    int last_gate;
    int last_clear;
    int last_gap;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, got, exp, n);
        end
    endtask

    function automatic int clampp(input int p);
        return (p < 16) ? 16 : p;
    endfunction

    task automatic start_meas(input int s);
        m_active = 1'b1;
        m_start  = s;
        m_len    = m_shadow;
        m_hold   = g_hold;
        m_lat    = (g_lat > 0) ? g_lat : int'($urandom_range(1, 6));
        if (!m_hold) begin
            m_end = s + m_len + m_lat + 2;
        end else begin
`ifdef GATE_TIMEOUT_EN
            m_end = s + m_len + 64;
`else
            m_end = -1;
`endif
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_err      = 1'b0;
        m_shadow   = 1200;
        m_start    = 0;
        m_len      = 1200;
        m_end      = -1;
        last_clear = -1;
        run        = 0;
    endtask

    // One clock: check outputs, observe, drive inputs, advance model
    task automatic step();
        int k;
        bit e_clr;
        bit e_en;
        bit e_st;
        bit e_ld;
        bit d;
        @(negedge clk);
        n++;
        k     = n - m_start;
        e_clr = m_active && (k == 0);
        e_en  = m_active && (k >= 1) && (k <= m_len);
        e_st  = m_active && (k == m_len + 1);
        e_ld  = m_active && !m_hold && (n == m_end);
        chk("count_clear", 32'(bus.count_clear), 32'(e_clr));
        chk("count_en", 32'(bus.count_en), 32'(e_en));
        chk("convert_start", 32'(bus.convert_start), 32'(e_st));
        chk("display_load", 32'(bus.display_load), 32'(e_ld));
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("conv_error", 32'(bus.conv_error), 32'(m_err));
        if (bus.count_clear === 1'b1) begin
            if (last_clear >= 0) last_gap = n - last_clear;
            last_clear = n;
            clears++;
        end
        if (bus.count_en === 1'b1) begin
            run++;
        end else if (run > 0) begin
            last_gate = run;
            run = 0;
        end
        if (bus.convert_start === 1'b1) starts++;
        if (bus.display_load === 1'b1) loads++;
        d = m_active && !m_hold && (n == m_start + m_len + 1 + m_lat);
        if (!d && g_noise && (!m_active || k <= m_len + 1))
            d = ($urandom_range(0, 3) == 0);
        bus.convert_done = d;
        bus.enable       = g_en;
        bus.period_load  = g_ld;
        bus.period       = BITS'(g_pv);
        if (g_ld) m_shadow = clampp(g_pv);
        g_ld = 1'b0;
        if (!m_active) begin
            if (g_en) start_meas(n + 1);
        end else if (n == m_end) begin
            if (m_hold) m_err = 1'b1;
            if (g_en) start_meas(n + 1);
            else m_active = 1'b0;
        end
    endtask

    task automatic wait_clears(input int cnt, input int budget,
                               input string name);
        int target;
        target = clears + cnt;
        for (int i = 0; i < budget && clears < target; i++) step();
        chk(name, 32'(clears >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && bus.busy !== 1'b0; i++) step();
        chk(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic load(input int pv);
        g_ld = 1'b1;
        g_pv = pv;
        step();
    endtask

    initial begin
        int l0;
        int exp_len[3];
        int pvs[3];
        reset_n          = 1'b0;
        bus.enable       = 1'b0;
        bus.period_load  = 1'b0;
        bus.period       = '0;
        bus.convert_done = 1'b0;
        g_en = 0; g_noise = 0; g_hold = 0; g_ld = 0; g_lat = 0; g_pv = 0;
        clears = 0; loads = 0; starts = 0; last_gate = 0; last_gap = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count_clear", 32'(bus.count_clear), 32'd0);
        chk("rst_count_en", 32'(bus.count_en), 32'd0);
        chk("rst_convert_start", 32'(bus.convert_start), 32'd0);
        chk("rst_display_load", 32'(bus.display_load), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_conv_error", 32'(bus.conv_error), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();

        // Default loop, converter answers 3 cycles after start
        g_en  = 1'b1;
        g_lat = 3;
        wait_clears(3, 4000, "t1_wait");
        chk("t1_gate_len", 32'(last_gate), 32'd1200);
        chk("t1_period", 32'(last_gap), 32'd1206);
        chk("t1_loads", 32'(loads), 32'd2);
        chk("t1_starts", 32'(starts), 32'd2);

        // Load during GATE: running gate unchanged, next one 20
        repeat (5) step();
        load(20);
        wait_clears(1, 2000, "t2_wait_a");
        chk("t2_current_gate", 32'(last_gate), 32'd1200);
        wait_clears(1, 200, "t2_wait_b");
        chk("t2_next_gate", 32'(last_gate), 32'd20);
        chk("t2_period", 32'(last_gap), 32'd26);

        // Clamp to minimum
        pvs = '{5, 40, 0};
        exp_len = '{16, 40, 16};
        for (int i = 0; i < 3; i++) begin
            load(pvs[i]);
            wait_clears(2, 400, "t3_wait");
            chk("t3_gate_len", 32'(last_gate), 32'(exp_len[i]));
        end

        // Enable dropped mid-gate: gate still runs to full length
        load(1200);
        wait_clears(1, 200, "t4_wait");
        repeat (500) step();
        g_en = 1'b0;
        l0 = loads;
        wait_idle(2000, "t4_idle");
        chk("t4_gate_len", 32'(last_gate), 32'd1200);
        chk("t4_load_fired", 32'(loads - l0), 32'd1);

        // Randomized traffic
        g_lat   = 0;
        g_noise = 1'b1;
        g_en    = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) == 0) g_en = !g_en;
            if ($urandom_range(0, 29) == 0) begin
                g_ld = 1'b1;
                g_pv = int'($urandom_range(0, 70));
            end
            step();
        end
        g_noise = 1'b0;
        g_en    = 1'b0;
        wait_idle(3000, "rand_idle");

        // Asynchronous reset in the middle of a gate
        g_lat = 3;
        g_en  = 1'b1;
        load(30);
        wait_clears(1, 50, "t5_wait");
        repeat (10) step();
        chk("t5_en_before", 32'(bus.count_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_en_async", 32'(bus.count_en), 32'd0);
        chk("t5_busy_async", 32'(bus.busy), 32'd0);
        model_reset();
        bus.enable       = 1'b0;
        bus.period_load  = 1'b0;
        bus.convert_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_clears(2, 3000, "t5_wait_b");
        chk("t5_gate_default", 32'(last_gate), 32'd1200);

        // Converter never answers
        load(16);
        wait_clears(1, 1300, "t6_wait_a");
        g_hold = 1'b1;
        wait_clears(1, 200, "t6_wait_b");
        l0 = loads;
`ifdef GATE_TIMEOUT_EN
        wait_clears(1, 200, "t6_wait_c");
        chk("t6_period", 32'(last_gap), 32'd81);
        chk("t6_no_load", 32'(loads - l0), 32'd0);
        chk("t6_error", 32'(bus.conv_error), 32'd1);
`else
        repeat (300) step();
        chk("t6_busy", 32'(bus.busy), 32'd1);
        chk("t6_no_load", 32'(loads - l0), 32'd0);
        chk("t6_error", 32'(bus.conv_error), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
